// File: rtl/rect_plotter_pkg.sv
// Shared screen geometry, coordinate widths, FSM encoding and command layout
// for the rectangle fill engine and its command buffer.
package rect_plotter_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CW      = 3;

    // Screen limits sized to the one-bit-wider pixel address sums.
    localparam logic [XW:0] X_LIMIT = XSCREEN[XW:0];
    localparam logic [YW:0] Y_LIMIT = YSCREEN[YW:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [CW-1:0] colour;
    } rect_cmd_t;

    localparam int CMD_BITS = $bits(rect_cmd_t);

    function automatic logic is_empty(input rect_cmd_t c);
        return (c.w == '0) || (c.h == '0);
    endfunction

endpackage

// File: rtl/rect_cmd_buffer.sv
// One-entry valid/ready holding register for a rectangle command; the
// engine drains it with out_take while the next command can queue up.
module rect_cmd_buffer
    import rect_plotter_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CMD_BITS-1:0] in_cmd,
    output logic                out_valid,
    output logic [CMD_BITS-1:0] out_cmd,
    input  logic                out_take
);

    logic                pend_valid;
    logic [CMD_BITS-1:0] pend_cmd;
    logic                accept;

    assign accept = in_valid && !pend_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
        end else if (out_take) begin
            pend_valid <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; it is only ever read while pend_valid is set.
    always_ff @(posedge clock) begin
        if (accept) begin
            pend_cmd <= in_cmd;
        end
    end

    assign in_ready  = !pend_valid;
    assign out_valid = pend_valid;
    assign out_cmd   = pend_cmd;

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine feeding vga_adapter: walks each buffered rectangle
// in raster order, one pixel per clock, suppressing plot for off-screen pixels.
module rect_plotter
    import rect_plotter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    state_t              state;
    state_t              state_next;
    rect_cmd_t           in_cmd;
    rect_cmd_t           pend;
    logic [CMD_BITS-1:0] pend_bits;
    logic                pend_valid;
    logic                take;

    rect_cmd_t           act;
    logic [XW-1:0]       cx;
    logic [YW-1:0]       cy;
    logic                last_col;
    logic                last_row;
    logic [XW:0]         px;
    logic [YW:0]         py;
    logic                filling;

    assign in_cmd = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, colour: cmd_colour};

    rect_cmd_buffer u_buffer (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (cmd_valid),
        .in_ready  (cmd_ready),
        .in_cmd    (in_cmd),
        .out_valid (pend_valid),
        .out_cmd   (pend_bits),
        .out_take  (take)
    );

    assign pend = rect_cmd_t'(pend_bits);
    assign take = (state == ST_IDLE) && pend_valid;

    assign last_col = (cx == act.w - XW'(1));
    assign last_row = (cy == act.h - YW'(1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            act   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                act <= pend;
                cx  <= '0;
                cy  <= '0;
            end else if (state == ST_FILL) begin
                if (last_col) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end
        end
    end

    // NOTE: state_next gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    state_next = is_empty(pend) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (last_col && last_row) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Addresses are one bit wider so pixels past the right/bottom edge clip instead of wrapping.
    assign px      = {1'b0, act.x} + {1'b0, cx};
    assign py      = {1'b0, act.y} + {1'b0, cy};
    assign filling = (state == ST_FILL);

    assign vga_x      = filling ? px[XW-1:0] : '0;
    assign vga_y      = filling ? py[YW-1:0] : '0;
    assign vga_colour = filling ? act.colour : '0;
    assign plot       = filling && (px < X_LIMIT) && (py < Y_LIMIT);
    assign done       = (state == ST_DONE);
    assign busy       = (state != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: a per-cycle timeline of expected
// outputs built from command arithmetic, plus directed literal checks.
module tb_rect_plotter;
    import rect_plotter_pkg::*;

    localparam int MAXC = 16384;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [XW-1:0] cmd_w;
    logic [YW-1:0] cmd_h;
    logic [CW-1:0] cmd_colour;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          plot;
    logic          busy;
    logic          done;

    rect_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Period t is the interval after rising edge t; outputs are sampled at its falling edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit            plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
        bit            done;
        bit            busy;
        bit            ready;
    } exp_t;

    exp_t exp_q [MAXC];
    int   eng_free = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   last_acc = 0;

    task automatic check(input string name, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic clear_from(input int r);
        for (int t = r; t < MAXC; t++) begin
            exp_q[t] = '{plot: 1'b0, x: '0, y: '0, col: '0, done: 1'b0, busy: 1'b0, ready: 1'b1};
        end
        eng_free = r;
    endtask

    // Command accepted at edge a: it loads once the engine is idle, plots w*h
    // pixels, then spends one cycle in done and one idle before the next load.
    task automatic schedule(input int a, input rect_cmd_t c);
        int l;
        int n;
        int px;
        int py;
        l = ((a > eng_free) ? a : eng_free) + 1;
        n = int'(c.w) * int'(c.h);
        for (int t = a; t < l && t < MAXC; t++) exp_q[t].ready = 1'b0;
        for (int t = a; t <= l + n && t < MAXC; t++) exp_q[t].busy = 1'b1;
        for (int k = 0; k < n && l + k < MAXC; k++) begin
            px = int'(c.x) + k % int'(c.w);
            py = int'(c.y) + k / int'(c.w);
            exp_q[l+k].plot = (px < XSCREEN) && (py < YSCREEN);
            exp_q[l+k].x    = px[XW-1:0];
            exp_q[l+k].y    = py[YW-1:0];
            exp_q[l+k].col  = c.colour;
        end
        if (l + n < MAXC) exp_q[l+n].done = 1'b1;
        eng_free = l + n + 1;
        last_acc = a;
    endtask

    function automatic rect_cmd_t mk(input int x, input int y, input int w, input int h, input int c);
        rect_cmd_t r;
        r.x      = XW'(x);
        r.y      = YW'(y);
        r.w      = XW'(w);
        r.h      = YW'(h);
        r.colour = CW'(c);
        return r;
    endfunction

    // Drives one period of inputs, updates the model, and advances to the next sample point.
    task automatic step(input bit v, input rect_cmd_t c, input bit rst_lvl);
        cmd_valid  = v;
        cmd_x      = c.x;
        cmd_y      = c.y;
        cmd_w      = c.w;
        cmd_h      = c.h;
        cmd_colour = c.colour;
        reset      = rst_lvl;
        if (!rst_lvl) clear_from(cyc + 1);
        else if (v && exp_q[cyc].ready) schedule(cyc + 1, c);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b1);
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) check("wait_until overshoot", cyc, t);
        while (cyc < t) idle();
    endtask

    task automatic drain();
        int guard = 0;
        while (cyc <= eng_free && guard < 2000) begin
            idle();
            guard++;
        end
        if (guard >= 2000) check("drain budget", cyc, eng_free);
        idle();
    endtask

    // Timeline comparison on every sampled period after the first reset edge.
    always @(negedge clock) begin
        if (cyc >= 1 && cyc < MAXC) begin
            exp_t e;
            e = exp_q[cyc];
            n_compared++;
            if (plot !== e.plot || vga_x !== e.x || vga_y !== e.y || vga_colour !== e.col ||
                done !== e.done || busy !== e.busy || cmd_ready !== e.ready) begin
                n_mismatched++;
                if (n_mismatched <= 20)
                    $display("FAIL timeline cycle %0d: got plot=%0b x=%0d y=%0d col=%0d done=%0b busy=%0b ready=%0b, want plot=%0b x=%0d y=%0d col=%0d done=%0b busy=%0b ready=%0b",
                             cyc, plot, vga_x, vga_y, vga_colour, done, busy, cmd_ready,
                             e.plot, e.x, e.y, e.col, e.done, e.busy, e.ready);
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit done_seen;
        rect_cmd_t c;

        cmd_valid  = 1'b0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;
        reset      = 1'b0;
        clear_from(0);

        // Reset held for three cycles.
        while (cyc < 3) step(1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        check("reset plot", int'(plot), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset vga_x", int'(vga_x), 0);
        check("reset vga_y", int'(vga_y), 0);
        idle();

        // Paddle.
        step(1'b1, mk(39, 100, 20, 1, 7), 1'b1);
        n = last_acc;
        wait_until(n + 1);
        check("paddle first plot", int'(plot), 1);
        check("paddle first x", int'(vga_x), 39);
        check("paddle y", int'(vga_y), 100);
        check("paddle colour", int'(vga_colour), 7);
        wait_until(n + 20);
        check("paddle last plot", int'(plot), 1);
        check("paddle last x", int'(vga_x), 58);
        wait_until(n + 21);
        check("paddle done", int'(done), 1);
        check("paddle plot after", int'(plot), 0);
        drain();

        // Raster order.
        step(1'b1, mk(10, 5, 3, 2, 2), 1'b1);
        n = last_acc;
        for (int k = 0; k < 6; k++) begin
            int wx [6] = '{10, 11, 12, 10, 11, 12};
            int wy [6] = '{5, 5, 5, 6, 6, 6};
            wait_until(n + 1 + k);
            check("raster x", int'(vga_x), wx[k]);
            check("raster y", int'(vga_y), wy[k]);
        end
        wait_until(n + 7);
        check("raster done", int'(done), 1);
        drain();

        // Right-edge clipping.
        step(1'b1, mk(158, 0, 4, 1, 4), 1'b1);
        n = last_acc;
        wait_until(n + 1);
        check("clip plot 158", int'(plot), 1);
        check("clip x 158", int'(vga_x), 158);
        wait_until(n + 2);
        check("clip plot 159", int'(plot), 1);
        wait_until(n + 3);
        check("clip plot 160", int'(plot), 0);
        wait_until(n + 4);
        check("clip plot 161", int'(plot), 0);
        wait_until(n + 5);
        check("clip done", int'(done), 1);
        drain();

        // Back-to-back erase then draw.
        step(1'b1, mk(0, 0, 5, 2, 0), 1'b1);
        n = last_acc;
        wait_until(n + 3);
        check("b2b ready during fill", int'(cmd_ready), 1);
        step(1'b1, mk(20, 30, 2, 2, 5), 1'b1);
        check("b2b ready after accept", int'(cmd_ready), 0);
        wait_until(n + 11);
        check("b2b erase done", int'(done), 1);
        check("b2b ready still held", int'(cmd_ready), 0);
        wait_until(n + 12);
        check("b2b gap plot", int'(plot), 0);
        wait_until(n + 13);
        check("b2b draw plot", int'(plot), 1);
        check("b2b draw x", int'(vga_x), 20);
        check("b2b draw y", int'(vga_y), 30);
        check("b2b ready after load", int'(cmd_ready), 1);
        drain();

        // Empty rectangle.
        step(1'b1, mk(5, 5, 0, 4, 1), 1'b1);
        n = last_acc;
        check("empty no plot", int'(plot), 0);
        wait_until(n + 1);
        check("empty done", int'(done), 1);
        check("empty plot", int'(plot), 0);
        drain();

        // Reset mid-fill.
        step(1'b1, mk(50, 50, 10, 3, 6), 1'b1);
        n = last_acc;
        wait_until(n + 4);
        check("midfill plot", int'(plot), 1);
        check("midfill x", int'(vga_x), 53);
        step(1'b0, mk(0, 0, 0, 0, 0), 1'b0);
        check("midfill reset plot", int'(plot), 0);
        check("midfill reset busy", int'(busy), 0);
        done_seen = 1'b0;
        for (int k = 0; k < 35; k++) begin
            idle();
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("midfill no done", int'(done_seen), 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000 && cyc < MAXC - 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b0, mk(0, 0, 0, 0, 0), 1'b0);
                step(1'b0, mk(0, 0, 0, 0, 0), 1'b0);
            end else begin
                c = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                       ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20)),
                       ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6)),
                       int'($urandom_range(0, 7)));
                step($urandom_range(0, 2) != 0, c, 1'b1);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
